// File: rtl/dma_ram_responder.sv
// Memory-side responder for the tDMA RAM request port, backed by an internal word SRAM with wait states.
// Define DMA_RAM_BYTE_STROBE_EN for byte-granular writes; otherwise every in-range write updates the full word.
module dma_ram_responder #(
    parameter int unsigned              DATA_WIDTH   = 32,
    parameter int unsigned              ADDRESS_BITS = 32,
    parameter int unsigned              DEPTH_WORDS  = 1024,
    parameter logic [ADDRESS_BITS-1:0]  BASE_ADDR    = '0,
    parameter int unsigned              WAIT_STATES  = 2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      ram_valid_i,
    input  logic                      ram_write_i,
    input  logic                      ram_read_i,
    input  logic [ADDRESS_BITS-1:0]   ram_address_i,
    input  logic [DATA_WIDTH/8-1:0]   ram_wstrb_i,
    input  logic [DATA_WIDTH-1:0]     ram_data_i,
    output logic [DATA_WIDTH-1:0]     ram_data_o,
    output logic                      ram_ready_o,
    output logic                      ram_done_o,
    output logic                      err_o
);
    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = $clog2(BYTES);
    localparam int unsigned IDX_BITS = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [DATA_WIDTH-1:0] OOR_DATA = {(DATA_WIDTH/32){32'hDEAD_BEEF}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RELEASE} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    wr_q, wr_d;
    logic                    both_q, both_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
`ifdef DMA_RAM_BYTE_STROBE_EN
    logic [BYTES-1:0]        wstrb_q, wstrb_d;
`else
    logic                    unused_wstrb;
    assign unused_wstrb = ^ram_wstrb_i;
`endif

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    logic [ADDRESS_BITS-1:0] offset;
    logic [ADDRESS_BITS-1:0] word;
    logic [IDX_BITS-1:0]     idx;
    logic                    in_range;

    // Range is judged on the full word number so addresses past the SRAM never alias into it.
    assign offset   = addr_q - BASE_ADDR;
    assign word     = offset >> OFF_BITS;
    assign idx      = word[IDX_BITS-1:0];
    assign in_range = (addr_q >= BASE_ADDR) && (word < ADDRESS_BITS'(DEPTH_WORDS));

    assign ram_data_o  = rdata_q;
    assign ram_ready_o = ready_q;
    assign ram_done_o  = done_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef DMA_RAM_BYTE_STROBE_EN
            wstrb_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef DMA_RAM_BYTE_STROBE_EN
            wstrb_q <= wstrb_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        both_d  = both_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef DMA_RAM_BYTE_STROBE_EN
        wstrb_d = wstrb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ram_valid_i && (ram_write_i || ram_read_i)) begin
                    addr_d  = ram_address_i;
                    wdata_d = ram_data_i;
                    wr_d    = ram_write_i;
                    both_d  = ram_write_i && ram_read_i;
                    ready_d = 1'b0;
                    cnt_d   = '0;
`ifdef DMA_RAM_BYTE_STROBE_EN
                    wstrb_d = ram_wstrb_i;
`endif
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACCESS: begin
                done_d = 1'b1;
                err_d  = both_q || !in_range;
                if (!wr_q) begin
                    rdata_d = in_range ? mem[idx] : OOR_DATA;
                end
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!ram_valid_i) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SRAM array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (state_q == S_ACCESS && wr_q && in_range) begin
`ifdef DMA_RAM_BYTE_STROBE_EN
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
`else
            mem[idx] <= wdata_q;
`endif
        end
    end

endmodule

// File: tb/tb_dma_ram_responder.sv
// Randomized self-checking bench for dma_ram_responder: a 2-wait-state and a 0-wait-state instance
// checked against a word-level memory model.
`timescale 1ns/1ps
module tb_dma_ram_responder;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] DEAD  = 32'hDEAD_BEEF;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        valid [2];
    logic        wr    [2];
    logic        rd    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        done  [2];
    logic        err   [2];

    int n_chk  = 0;
    int n_fail = 0;
    int ws_of [2] = '{2, 0};

    logic [31:0] mem_m [int];
    logic [31:0] rdata_m     [2];
    bit          rdata_known [2];

    always #5 clk = ~clk;

    dma_ram_responder #(
        .DATA_WIDTH(32), .ADDRESS_BITS(32), .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)
    ) u_dut_ws2 (
        .clk_i(clk), .rstn_i(rstn),
        .ram_valid_i(valid[0]), .ram_write_i(wr[0]), .ram_read_i(rd[0]),
        .ram_address_i(addr[0]), .ram_wstrb_i(wstrb[0]), .ram_data_i(wdata[0]),
        .ram_data_o(rdata[0]), .ram_ready_o(ready[0]), .ram_done_o(done[0]), .err_o(err[0])
    );

    dma_ram_responder #(
        .DATA_WIDTH(32), .ADDRESS_BITS(32), .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)
    ) u_dut_ws0 (
        .clk_i(clk), .rstn_i(rstn),
        .ram_valid_i(valid[1]), .ram_write_i(wr[1]), .ram_read_i(rd[1]),
        .ram_address_i(addr[1]), .ram_wstrb_i(wstrb[1]), .ram_data_i(wdata[1]),
        .ram_data_o(rdata[1]), .ram_ready_o(ready[1]), .ram_done_o(done[1]), .err_o(err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            rdata_m[k]     = 32'h0;
            rdata_known[k] = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input int k);
        check_eq("rst_ready", ready[k], 1);
        check_eq("rst_done",  done[k],  0);
        check_eq("rst_err",   err[k],   0);
        check_eq("rst_rdata", rdata[k], 0);
    endtask

    // One full request: present at idle, wait for done, hold valid 'extra' cycles past the sampling edge.
    task automatic txn(input int k, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input int extra);
        int          c;
        int          key;
        bit          inr;
        bit          exp_err;
        logic [31:0] mask;
        inr     = (a >> 2) < DEPTH;
        key     = k * int'(DEPTH) + int'((a >> 2) % DEPTH);
        exp_err = (w && r) || !inr;
        mask    = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};

        check_eq("ready_idle", ready[k], 1);
        valid[k] = 1'b1; wr[k] = w; rd[k] = r;
        addr[k] = a; wdata[k] = d; wstrb[k] = s;
        @(posedge clk); #1;
        check_eq("ready_busy", ready[k], 0);
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        wstrb[k] = 4'($urandom);
        wr[k]    = 1'($urandom);
        rd[k]    = 1'($urandom);

        c = 0;
        while (!done[k] && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq("latency", c + 1, ws_of[k] + 2);

        if (w) begin
            if (inr) begin
`ifdef DMA_RAM_BYTE_STROBE_EN
                if (mem_m.exists(key)) mem_m[key] = (mem_m[key] & ~mask) | (d & mask);
                else if (s == 4'hF)    mem_m[key] = d;
`else
                mem_m[key] = d;
`endif
            end
        end else if (!inr) begin
            rdata_m[k] = DEAD; rdata_known[k] = 1'b1;
        end else if (mem_m.exists(key)) begin
            rdata_m[k] = mem_m[key]; rdata_known[k] = 1'b1;
        end else begin
            rdata_known[k] = 1'b0;
        end
        check_eq("err", err[k], exp_err);
        if (rdata_known[k]) check_eq("rdata", rdata[k], rdata_m[k]);

        @(posedge clk); #1;
        check_eq("done_pulse", done[k], 0);
        check_eq("err_pulse", err[k], 0);
        check_eq("ready_release", ready[k], 0);
        for (int i = 0; i < extra; i++) begin
            @(posedge clk); #1;
            check_eq("done_hold", done[k], 0);
            check_eq("ready_hold", ready[k], 0);
        end
        valid[k] = 1'b0; wr[k] = 1'b0; rd[k] = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_return", ready[k], 1);
        check_eq("done_after", done[k], 0);
    endtask

    task automatic random_txns(input int k, input int n);
        int          op;
        logic [31:0] a;
        logic [3:0]  s;
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + ($urandom_range(0, 255) << 2);
            else                           a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            txn(k, op <= 4 || op == 9, op >= 5, a, $urandom, s, $urandom_range(0, 2));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0; wr[k] = 1'b0; rd[k] = 1'b0;
            addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
        end
        reset_model();
        #12;
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // valid without read or write must be ignored
        valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("noop_ready", ready[0], 1);
            check_eq("noop_done", done[0], 0);
        end
        valid[0] = 1'b0;
        @(posedge clk); #1;

        txn(0, 1, 0, 32'h10, 32'hA5A5_1234, 4'hF, 0);
        txn(0, 0, 1, 32'h10, 32'h0, 4'h0, 0);
        check_eq("full_const", rdata[0], 32'hA5A5_1234);
        txn(0, 1, 0, 32'h10, 32'h0000_FF00, 4'b0010, 0);
        txn(0, 0, 1, 32'h10, 32'h0, 4'h0, 0);
`ifdef DMA_RAM_BYTE_STROBE_EN
        check_eq("partial_const", rdata[0], 32'hA5A5_FF34);
`else
        check_eq("partial_const", rdata[0], 32'h0000_FF00);
`endif
        txn(0, 1, 0, 32'h10, 32'h1234_5678, 4'h0, 0);
        txn(0, 0, 1, 32'h13, 32'h0, 4'h0, 0);

        txn(0, 1, 0, 32'h0, 32'h0BAD_0000, 4'hF, 0);
        txn(0, 0, 1, 32'(DEPTH * 4), 32'h0, 4'h0, 0);
        check_eq("oor_const", rdata[0], DEAD);
        txn(0, 1, 0, 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF, 0);
        txn(0, 0, 1, 32'h0, 32'h0, 4'h0, 0);

        txn(0, 1, 0, 32'h40, 32'h5555_AAAA, 4'hF, 5);
        txn(0, 1, 1, 32'h44, 32'h7777_8888, 4'hF, 0);
        txn(0, 0, 1, 32'h44, 32'h0, 4'h0, 1);

        // reset while a write sits in WAIT must drop the write
        txn(0, 1, 0, 32'h20, 32'h1111_1111, 4'hF, 0);
        valid[0] = 1'b1; wr[0] = 1'b1; rd[0] = 1'b0;
        addr[0] = 32'h20; wdata[0] = 32'h2222_2222; wstrb[0] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check_reset_outputs(0);
        valid[0] = 1'b0; wr[0] = 1'b0;
        reset_model();
        @(posedge clk); #1;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        txn(0, 0, 1, 32'h20, 32'h0, 4'h0, 0);
        check_eq("rst_keep_const", rdata[0], 32'h1111_1111);

        txn(1, 1, 0, 32'h30, 32'hCAFE_F00D, 4'hF, 0);
        txn(1, 0, 1, 32'h30, 32'h0, 4'h0, 0);
        check_eq("ws0_const", rdata[1], 32'hCAFE_F00D);

        random_txns(0, 40);
        random_txns(1, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
